// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin request arbiter.
package arb_pkg;
  localparam int N     = 8;
  localparam int PTR_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of vec scanning upward from ptr+1,
// wrapping through index 0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     vec,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] start;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [PTR_W-1:0] off;

  assign start = ptr + PTR_W'(1);
  assign dbl   = {vec, vec};
  // Rotate so the search origin lands at bit 0.
  assign rot   = dbl[start +: N];

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = PTR_W'(j);
        any = 1'b1;
      end
    end
  end

  assign idx    = start + off;
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_request_arbiter.sv
// Latches request strobes and grants them one at a time, round-robin,
// as a registered one-hot bus with a valid flag.
module rr_request_arbiter
  import arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic [N-1:0] gnt_onehot,
  output logic         gnt_valid,
  output logic [N-1:0] pending
);

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] gnt_idx_nxt;
  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] pick_idx;
  logic [N-1:0]     clr_mask;
  logic [N-1:0]     pend_nxt;
  logic [N-1:0]     onehot_nxt;
  logic [N-1:0]     pick_onehot;
  logic             valid_nxt;
  logic             hs;
  logic             pick_any;

  assign hs       = gnt_valid & gnt_ready;
  assign clr_mask = hs ? gnt_onehot : '0;
  // A fresh req on the granted bit survives its own handshake.
  assign pend_nxt = (pending & ~clr_mask) | req;
  // In GRANT the pick only matters at handshake, when ptr moves to gnt_idx.
  assign base     = (state == GRANT) ? gnt_idx : ptr;

  rr_pick u_pick (
    .vec    (pend_nxt),
    .ptr    (base),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_idx_nxt = gnt_idx;
    onehot_nxt  = gnt_onehot;
    valid_nxt   = gnt_valid;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          onehot_nxt  = pick_onehot;
          gnt_idx_nxt = pick_idx;
          valid_nxt   = 1'b1;
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          ptr_nxt = gnt_idx;
          if (pick_any) begin
            onehot_nxt  = pick_onehot;
            gnt_idx_nxt = pick_idx;
          end else begin
            onehot_nxt = '0;
            valid_nxt  = 1'b0;
            state_nxt  = IDLE;
          end
        end
      end
      default: begin
        onehot_nxt = '0;
        valid_nxt  = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= PTR_W'(N - 1);
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      gnt_valid  <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gnt_idx    <= gnt_idx_nxt;
      gnt_onehot <= onehot_nxt;
      gnt_valid  <= valid_nxt;
      pending    <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed bench for rr_request_arbiter with hand-computed grant sequences.
module tb_rr_request_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_ready;
  logic [7:0] gnt_onehot;
  logic       gnt_valid;
  logic [7:0] pending;

  int checks;
  int failures;

  rr_request_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_onehot (gnt_onehot),
    .gnt_valid  (gnt_valid),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("invariant",
        {7'd0, $onehot0(gnt_onehot) && ((gnt_onehot != 8'h00) == gnt_valid)},
        8'h01);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = 8'h00;
    gnt_ready = 1'b0;

    // 1 reset
    #12;
    chk("rst_valid", {7'd0, gnt_valid}, 8'h00);
    chk("rst_onehot", gnt_onehot, 8'h00);
    chk("rst_pending", pending, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", {7'd0, gnt_valid}, 8'h00);
      chk("idle_onehot", gnt_onehot, 8'h00);
      chk("idle_pending", pending, 8'h00);
    end

    // 2 single pulse
    gnt_ready = 1'b1;
    req = 8'b0000_1000;
    step();
    req = 8'h00;
    chk("single_onehot", gnt_onehot, 8'b0000_1000);
    chk("single_valid", {7'd0, gnt_valid}, 8'h01);
    step();
    chk("single_done_valid", {7'd0, gnt_valid}, 8'h00);
    chk("single_done_pending", pending, 8'h00);

    // 3 simultaneous, from reset (ptr=7)
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'b1000_0001;
    step();
    req = 8'h00;
    chk("sim_first", gnt_onehot, 8'b0000_0001);
    step();
    chk("sim_second", gnt_onehot, 8'b1000_0000);
    step();
    chk("sim_idle", {7'd0, gnt_valid}, 8'h00);

    // 4 backpressure on bit 6 (ptr=7)
    gnt_ready = 1'b0;
    req = 8'b0100_0000;
    step();
    req = 8'h00;
    chk("bp_grant", gnt_onehot, 8'b0100_0000);
    req = 8'b0000_0010;
    step();
    chk("bp_hold1", gnt_onehot, 8'b0100_0000);
    req = 8'h00;
    step();
    chk("bp_hold2", gnt_onehot, 8'b0100_0000);
    req = 8'b0010_0000;
    step();
    chk("bp_hold3", gnt_onehot, 8'b0100_0000);
    req = 8'h00;
    step();
    chk("bp_hold4", gnt_onehot, 8'b0100_0000);
    chk("bp_valid", {7'd0, gnt_valid}, 8'h01);
    chk("bp_pending", pending, 8'b0110_0010);
    gnt_ready = 1'b1;
    step();
    chk("bp_next1", gnt_onehot, 8'b0000_0010);
    step();
    chk("bp_next5", gnt_onehot, 8'b0010_0000);
    step();
    chk("bp_idle", {7'd0, gnt_valid}, 8'h00);

    // 5 re-request on handshake (ptr=5)
    gnt_ready = 1'b0;
    req = 8'b0000_1000;
    step();
    chk("rr_grant3", gnt_onehot, 8'b0000_1000);
    req = 8'b0001_0000;
    step();
    chk("rr_hold3", gnt_onehot, 8'b0000_1000);
    chk("rr_pend", pending, 8'b0001_1000);
    gnt_ready = 1'b1;
    req = 8'b0000_1000;
    step();
    req = 8'h00;
    chk("rr_grant4", gnt_onehot, 8'b0001_0000);
    chk("rr_pend_keep", pending, 8'b0001_1000);
    step();
    chk("rr_regrant3", gnt_onehot, 8'b0000_1000);
    chk("rr_pend3", pending, 8'b0000_1000);
    step();
    chk("rr_idle", {7'd0, gnt_valid}, 8'h00);
    chk("rr_pend_clr", pending, 8'h00);

    // 6 async reset mid-grant (ptr=3)
    gnt_ready = 1'b0;
    req = 8'hFF;
    step();
    chk("ar_grant4", gnt_onehot, 8'b0001_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {7'd0, gnt_valid}, 8'h00);
    chk("ar_onehot", gnt_onehot, 8'h00);
    chk("ar_pending", pending, 8'h00);
    #1 rst_n = 1'b1;
    step();
    chk("ar_restart", gnt_onehot, 8'b0000_0001);
    req = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
